// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch front-end.
//   ADDR_W_DEF / INST_W_DEF : default address and instruction widths
//   PC_INC                  : byte increment between sequential fetches
//   NOP                     : all-zero instruction shown on id_inst when idle
//   state_t                 : fetch FSM encoding {IDLE, RUN, FLUSH}
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;
    localparam int PC_INC     = 4;

    localparam logic [INST_W_DEF-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port, redirect input and the
// decode-side handshake of the fetch unit, bundled as one interface.
//   imem_req/imem_addr  : read request and word-aligned address
//   imem_rdata          : read data, valid the cycle after imem_req
//   redir_valid/redir_pc: branch/jump redirect from execute
//   id_valid/id_ready   : decode handshake, id_inst/id_pc carried with it
// Handshake: a transfer happens on every rising edge where id_valid and
// id_ready are both 1; while id_valid=1 and id_ready=0 the payload holds.
// Modports: master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc,
        input  imem_rdata, redir_valid, redir_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc,
        output imem_rdata, redir_valid, redir_pc, id_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, inst} entries.
//   clk, rst  : clock, synchronous active-high reset
//   push/din  : write an entry (ignored while flush is high)
//   pop/dout  : read the head entry; dout is the current head
//   flush     : empty the FIFO; has priority over push and pop
//   full/empty/count : occupancy status
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs while the index bits match.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // The upstream credit scheme must never push into a full FIFO
    // unless the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end feeding decode.
//   clk, rst   : core clock, synchronous active-high reset
//   bus        : fetch_unit_if.master (imem read port, redirect, decode handshake)
//   dbg_state  : current fetch FSM state
//   perf_fetched, perf_stall : saturating counters, present only when
//                the FETCH_PERF_EN macro is defined
// A request is issued only when its returning word is guaranteed a FIFO
// slot: occupancy after this cycle's pop plus the word returning this
// cycle must be below FIFO_DEPTH. On redirect the FIFO is flushed, the
// PC reloads, and the epoch flips so a word requested in the redirect
// cycle is dropped when it returns.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INST_W     = INST_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output state_t        dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    state_t            state_q;
    state_t            state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc_q;
    logic              inflight_q;
    logic              req_epoch_q;
    logic              epoch_q;

    logic              redirect;
    logic              pop;
    logic              push;
    logic              issue;
    logic              id_valid;
    logic [CW:0]       occ;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [AW:0]              fifo_count;
    logic [ADDR_W+INST_W-1:0] fifo_dout;
    logic [ADDR_W-1:0]        head_pc;
    logic [INST_W-1:0]        head_inst;

    assign redirect = bus.redir_valid && (state_q != IDLE);
    assign id_valid = !fifo_empty;
    assign pop      = id_valid && bus.id_ready;
    assign push     = inflight_q && (req_epoch_q == epoch_q);
    assign occ      = {1'b0, fifo_count} - (CW+1)'(pop) + (CW+1)'(inflight_q);
    assign issue    = (state_q == RUN) && (occ < (CW+1)'(FIFO_DEPTH));

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({req_pc_q, bus.imem_rdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_pc, head_inst} = fifo_dout;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.id_valid  = id_valid;
    assign bus.id_inst   = fifo_empty ? INST_W'(NOP) : head_inst;
    assign bus.id_pc     = fifo_empty ? '0 : head_pc;
    assign dbg_state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    state_n = RUN;
            RUN:     if (redirect) state_n = FLUSH;
            FLUSH:   state_n = redirect ? FLUSH : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc_q    <= RESET_PC;
            inflight_q  <= 1'b0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q    <= fetch_pc;
                req_epoch_q <= epoch_q;
            end
            if (redirect) begin
                fetch_pc <= bus.redir_pc & ~ADDR_W'(3);
                epoch_q  <= ~epoch_q;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end
        end
    end

    // A full FIFO with no pop leaves no credit, so nothing may issue.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && !pop && issue));

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if ((state_q == RUN) && bus.id_ready && !id_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
